// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - instruction formats, opcodes, function codes and field positions shared with the decoder
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    function automatic logic legal_func(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
            FN_SLL, FN_SRL, FN_SRA, FN_JR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic legal_iop(input logic [5:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic legal_jop(input logic [5:0] op);
        case (op)
            OP_J, OP_JAL: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of one descriptor into a 32-bit word plus legality flag
module instr_pack
    import instr_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt_t'(fmt))
            FMT_R: begin
                word[OP_MSB:OP_LSB] = OP_RTYPE;
                word[RS_MSB:RS_LSB] = rs;
                word[RT_MSB:RT_LSB] = rt;
                word[RD_MSB:RD_LSB] = rd;
                word[SH_MSB:SH_LSB] = shamt;
                word[FN_MSB:FN_LSB] = func;
                legal               = legal_func(func);
            end
            FMT_I: begin
                word[OP_MSB:OP_LSB]   = op;
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = imm;
                legal                 = legal_iop(op);
            end
            FMT_J: begin
                word[OP_MSB:OP_LSB]   = op;
                word[TGT_MSB:TGT_LSB] = target;
                legal                 = legal_jop(op);
            end
            FMT_BAD: begin
                word  = '0;
                legal = 1'b0;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - descriptor-to-instruction-memory loader: FSM, write register, pointer and counter
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_func,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              legal;
    logic              xfer;
    logic              last_slot;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .func   (in_func),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state == S_LOAD);
    assign done      = (state == S_DONE);
    assign xfer      = in_valid && in_ready;
    // This transfer, if legal, takes the final free slot of the memory.
    assign last_slot = (count == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer && (in_last || (legal && last_slot))) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= '0;
            ptr       <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start && (state != S_LOAD)) begin
                ptr   <= base_addr;
                count <= '0;
                err   <= 1'b0;
            end else if (xfer) begin
                if (legal) begin
                    imem_we   <= 1'b1;
                    imem_addr <= ptr;
                    imem_wd   <= word;
                    ptr       <= ptr + PTR_ONE;
                    count     <= count + CNT_ONE;
                    if (last_slot && !in_last) begin
                        err <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
